// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one DATA_W-bit ALU between NUM_REQ requesters.
// A granted request is executed in a registered stage and returned as a tagged response.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ*2-1:0]      req_op,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W:0]           rsp_result,
  output logic                      busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_next;

  logic [ID_W-1:0]      last_grant;
  logic [ID_W-1:0]      winner;
  logic [ID_W:0]        shamt;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [2*NUM_REQ-1:0] dbl_grant;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [NUM_REQ-1:0]   rot_grant;
  logic [NUM_REQ-1:0]   pick;
  logic                 grant;
  logic [DATA_W-1:0]    sel_a, sel_b;
  logic [1:0]           sel_op;
  logic [DATA_W-1:0]    a_q, b_q;
  logic [1:0]           op_q;
  logic [DATA_W:0]      alu_out;

  // Rotate so bit 0 is the requester after last_grant, take the lowest set bit,
  // then rotate back; the doubled vectors make the wrap-around free.
  assign shamt     = {1'b0, last_grant} + (ID_W+1)'(1);
  assign dbl_valid = {req_valid, req_valid} >> shamt;
  assign rot_valid = dbl_valid[NUM_REQ-1:0];
  assign rot_grant = rot_valid & (~rot_valid + NUM_REQ'(1));
  assign dbl_grant = {{NUM_REQ{1'b0}}, rot_grant} << shamt;
  assign pick      = dbl_grant[NUM_REQ-1:0] | dbl_grant[2*NUM_REQ-1:NUM_REQ];

  always_comb begin
    winner = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        winner = ID_W'(i);
        sel_a  = req_a[i*DATA_W +: DATA_W];
        sel_b  = req_b[i*DATA_W +: DATA_W];
        sel_op = req_op[i*2 +: 2];
      end
    end
  end

  assign grant     = (state == IDLE) && (|req_valid);
  assign req_ready = (state == IDLE) ? pick : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (|req_valid) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_out = '0;
    unique case (op_q)
      2'b00: alu_out = {1'b0, a_q} + {1'b0, b_q};
      2'b01: alu_out = {1'b0, a_q} - {1'b0, b_q};
      2'b10: alu_out = {1'b0, a_q & b_q};
      2'b11: alu_out = {1'b0, a_q | b_q};
      default: alu_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= ID_W'(NUM_REQ-1);
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      if (grant) begin
        a_q        <= sel_a;
        b_q        <= sel_b;
        op_q       <= sel_op;
        rsp_id     <= winner;
        last_grant <= winner;
      end
      if (state == EXEC) rsp_result <= alu_out;
    end
  end

endmodule
